// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths used by the write-back stage and its queue.
package pipe_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic [DATA_W-1:0]    data;
    } wb_entry;

endpackage : pipe_pkg

// File: rtl/write_back_if.sv
// Bundle of the ALU, memory, register-file write and hazard-query signals of the write-back stage.
interface write_back_if
    import pipe_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 alu_valid;
    logic [REG_IDX_W-1:0] alu_dst;
    logic [DATA_W-1:0]    alu_data;
    logic                 alu_ready;

    logic                 mem_valid;
    logic [REG_IDX_W-1:0] mem_dst;
    logic [DATA_W-1:0]    mem_data;

    logic                 WriteReg;
    logic [REG_IDX_W-1:0] WriteRegdst;
    logic [DATA_W-1:0]    WriteRegData;

    logic [REG_IDX_W-1:0] hz_reg;
    logic                 hz_busy;
    logic [CNT_W-1:0]     pend_count;

    modport slave (
        input  alu_valid, alu_dst, alu_data,
        input  mem_valid, mem_dst, mem_data,
        input  hz_reg,
        output alu_ready,
        output WriteReg, WriteRegdst, WriteRegData,
        output hz_busy, pend_count
    );

    modport master (
        output alu_valid, alu_dst, alu_data,
        output mem_valid, mem_dst, mem_data,
        output hz_reg,
        input  alu_ready,
        input  WriteReg, WriteRegdst, WriteRegData,
        input  hz_busy, pend_count
    );

endinterface : write_back_if

// File: rtl/wb_fifo.sv
// FIFO of ALU results waiting for the register-file write port, with a per-entry
// destination compare used for hazard detection.
module wb_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  wb_entry              push_entry,
    input  logic                 pop,
    output wb_entry              head,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count,
    input  logic [REG_IDX_W-1:0] cmp_idx,
    output logic [DEPTH-1:0]     cmp_hit
);

    wb_entry            mem_q [DEPTH];
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        vld_d    = vld_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign cmp_hit[gi] = vld_q[gi] && (mem_q[gi].dst == cmp_idx);
        end
    endgenerate

endmodule : wb_fifo

// File: rtl/write_back.sv
// Write-back stage: merges load results and queued/bypassed ALU results onto a
// single registered register-file write port, loads taking priority.
module write_back
    import pipe_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    write_back_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 wr_q, wr_d;
    logic [REG_IDX_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0]    data_q, data_d;

    logic                 push, pop, accept;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [DEPTH-1:0]     fifo_hit;
    wb_entry              alu_entry, head;

    assign alu_entry = '{dst: bus.alu_dst, data: bus.alu_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (alu_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .cmp_idx    (bus.hz_reg),
        .cmp_hit    (fifo_hit)
    );

    // Ready depends only on the registered count, so a pop cannot free a slot
    // in the same cycle.
    assign bus.alu_ready = !fifo_full;
    assign accept        = bus.alu_valid && !fifo_full;

    always_comb begin
        wr_d   = 1'b0;
        dst_d  = dst_q;
        data_d = data_q;
        push   = 1'b0;
        pop    = 1'b0;
        if (bus.mem_valid) begin
            wr_d   = 1'b1;
            dst_d  = bus.mem_dst;
            data_d = bus.mem_data;
            push   = accept;
        end else if (!fifo_empty) begin
            wr_d   = 1'b1;
            dst_d  = head.dst;
            data_d = head.data;
            pop    = 1'b1;
            push   = accept;
        end else if (accept) begin
            wr_d   = 1'b1;
            dst_d  = bus.alu_dst;
            data_d = bus.alu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            dst_q  <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            dst_q  <= dst_d;
            data_q <= data_d;
        end
    end

    assign bus.WriteReg     = wr_q;
    assign bus.WriteRegdst  = dst_q;
    assign bus.WriteRegData = data_q;
    assign bus.pend_count   = fifo_count;
    assign bus.hz_busy      = (|fifo_hit) || (wr_q && (dst_q == bus.hz_reg));

endmodule : write_back

// File: tb/tb_write_back.sv
// Directed bench for write_back: a queue-based reference predicts each write,
// ready and occupancy, and results are compared one cycle at a time.
module tb_write_back;
    import pipe_pkg::*;

    localparam int DEPTH = WB_DEPTH;

    typedef struct {
        logic        v;
        logic [4:0]  d;
        logic [31:0] x;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    write_back_if #(.DEPTH(DEPTH)) bus ();

    write_back #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_entry     model_q [$];
    exp_t        sb [$];
    logic        last_v;
    logic [4:0]  last_d;
    logic [31:0] last_x;
    int          compared   = 0;
    int          mismatched = 0;
    logic        acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, predict, then check after the edge.
    task automatic step(input logic mv, input logic [4:0] md, input logic [31:0] mx,
                        input logic av, input logic [4:0] ad, input logic [31:0] ax,
                        output logic accepted);
        exp_t    e;
        wb_entry h;
        logic    rdy;
        @(negedge clk);
        bus.mem_valid = mv;
        bus.mem_dst   = md;
        bus.mem_data  = mx;
        bus.alu_valid = av;
        bus.alu_dst   = ad;
        bus.alu_data  = ax;
        #1;
        rdy = (model_q.size() < DEPTH);
        chk("alu_ready", 32'(bus.alu_ready), 32'(rdy));
        chk("pend_count", 32'(bus.pend_count), 32'(model_q.size()));
        accepted = av && rdy;
        e = '{1'b0, last_d, last_x};
        if (mv) begin
            e = '{1'b1, md, mx};
            if (accepted) model_q.push_back('{dst: ad, data: ax});
        end else if (model_q.size() > 0) begin
            h = model_q.pop_front();
            e = '{1'b1, h.dst, h.data};
            if (accepted) model_q.push_back('{dst: ad, data: ax});
        end else if (accepted) begin
            e = '{1'b1, ad, ax};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("WriteReg", 32'(bus.WriteReg), 32'(e.v));
        chk("WriteRegdst", 32'(bus.WriteRegdst), 32'(e.d));
        chk("WriteRegData", bus.WriteRegData, e.x);
        last_v = e.v;
        last_d = e.d;
        last_x = e.x;
    endtask

    task automatic idle();
        logic a;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && model_q.size() > 0; n++) idle();
        chk("drain_empty", 32'(model_q.size()), 32'd0);
    endtask

    task automatic check_hz(input logic [4:0] idx);
        logic exp;
        bus.hz_reg = idx;
        #1;
        exp = last_v && (last_d == idx);
        foreach (model_q[i]) if (model_q[i].dst == idx) exp = 1'b1;
        chk("hz_busy", 32'(bus.hz_busy), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_dst = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_dst = '0; bus.mem_data = '0;
        bus.hz_reg = '0;
        last_v = 1'b0; last_d = '0; last_x = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_WriteReg", 32'(bus.WriteReg), 32'd0);
        chk("rst_dst", 32'(bus.WriteRegdst), 32'd0);
        chk("rst_data", bus.WriteRegData, 32'd0);
        chk("rst_count", 32'(bus.pend_count), 32'd0);
        chk("rst_ready", 32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // ALU bypass with an empty queue
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h55, acc);
        chk("bypass_count", 32'(bus.pend_count), 32'd0);
        idle();

        // Loads held for 5 cycles while ALU results queue up to full
        for (int i = 1; i <= 5; i++)
            step(1'b1, 5'd7, 32'hA0, 1'b1, 5'(i), 32'(i * 32'h11), acc);
        chk("full_ready", 32'(bus.alu_ready), 32'd0);
        drain();

        // Load and ALU to the same register in one cycle
        step(1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2, acc);
        check_hz(5'd9);
        check_hz(5'd4);
        idle();
        check_hz(5'd9);
        idle();
        check_hz(5'd9);

        // Fill, then pop and push together so pointers wrap
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd8, 32'hB0 + 32'(i), 1'b1, 5'(16 + i), 32'hC00 + 32'(i), acc);
        k = 0;
        for (int n = 0; n < 16 && k < 8; n++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + k), 32'hD00 + 32'(k), acc);
            if (acc) k++;
        end
        chk("wrap_accepted", 32'(k), 32'd8);
        drain();

        // Register 0 is written like any other
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, acc);
        check_hz(5'd0);

        // Asynchronous reset with three pending entries
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd10, 32'hE0 + 32'(i), 1'b1, 5'(24 + i), 32'hF0 + 32'(i), acc);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_WriteReg", 32'(bus.WriteReg), 32'd0);
        chk("arst_count", 32'(bus.pend_count), 32'd0);
        chk("arst_ready", 32'(bus.alu_ready), 32'd1);
        model_q.delete();
        last_v = 1'b0; last_d = '0; last_x = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) idle();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'hCAFE, acc);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_write_back
